// File: rtl/uart_pkg.sv
// Shared DMI widths, error code and arbiter state type for the UART DTM slice.
package uart_pkg;

  localparam int unsigned DMI_REQ_W  = 41;  // {addr[40:34], data[33:2], op[1:0]}
  localparam int unsigned DMI_RESP_W = 34;  // {data[33:2], resp[1:0]}

  // Response code returned to a requester when dm_top never answers.
  localparam logic [1:0] DTM_ERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } dmi_arb_state_e;

endpackage

// File: rtl/dmi_arbiter.sv
// Two-requester DMI arbiter: round-robin grant, one transaction in flight,
// response routed back to the granted requester, error response on timeout.
module dmi_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned REQ_W          = DMI_REQ_W,
  parameter int unsigned RESP_W         = DMI_RESP_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [REQ_W-1:0]  req0_i,
  input  logic [REQ_W-1:0]  req1_i,
  output logic [1:0]        resp_valid_o,
  input  logic [1:0]        resp_ready_i,
  output logic [RESP_W-1:0] resp_o,
  output logic              dmi_req_valid_o,
  input  logic              dmi_req_ready_i,
  output logic [REQ_W-1:0]  dmi_req_o,
  input  logic              dmi_resp_valid_i,
  output logic              dmi_resp_ready_o,
  input  logic [RESP_W-1:0] dmi_resp_i,
  output logic              owner_o,
  output logic              timeout_o
);

  // A zero timeout still needs a legal (unused) one-bit counter.
  localparam int unsigned     CNT_W        = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [RESP_W-1:0] TIMEOUT_RESP = {{(RESP_W-2){1'b0}}, DTM_ERR};

  // Both valid: the side that did not win last time. Otherwise the valid one.
  function automatic logic rr_select(input logic [1:0] valid, input logic last);
    if (&valid) return ~last;
    return valid[1];
  endfunction

  dmi_arb_state_e    state_q, state_d;
  logic              owner_q, owner_d;
  logic [REQ_W-1:0]  dmi_req_q, dmi_req_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic [1:0]        req_ready_c;
  logic              grant;

  // Next-state logic: grant, issue, wait for response or timeout, deliver.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    owner_d     = owner_q;
    dmi_req_d   = dmi_req_q;
    resp_d      = resp_q;
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
    req_ready_c = 2'b00;
    grant       = rr_select(req_valid_i, owner_q);

    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          req_ready_c[grant] = 1'b1;
          dmi_req_d          = grant ? req1_i : req0_i;
          owner_d            = grant;
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        if (dmi_req_ready_i) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A real response beats a timeout that expires in the same cycle.
        if (dmi_resp_valid_i) begin
          resp_d  = dmi_resp_i;
          state_d = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          resp_d    = TIMEOUT_RESP;
          timeout_d = 1'b1;
          state_d   = RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous: it is only seen at a clock edge, exactly like a data input.
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b1;
      dmi_req_q <= '0;
      resp_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
      state_q   <= state_d;
      owner_q   <= owner_d;
      dmi_req_q <= dmi_req_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Handshake outputs; ready outputs are held low while reset is asserted.
  assign req_ready_o      = reset_n ? req_ready_c : 2'b00;
  assign dmi_resp_ready_o = reset_n && ((state_q == IDLE) || (state_q == WAIT));
  assign dmi_req_valid_o  = (state_q == ISSUE);
  assign resp_valid_o     = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign dmi_req_o        = dmi_req_q;
  assign resp_o           = resp_q;
  assign owner_o          = owner_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Bench for dmi_arbiter: directed table of grant patterns, hand-written
// stall / timeout / reset sequences, then randomized traffic against a
// transaction-level model.
module tb_dmi_arbiter;
  import uart_pkg::*;

  localparam int unsigned T = 8;
  localparam logic [33:0] ERR_RESP = {32'h0, DTM_ERR};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid_i, req_ready_o, resp_valid_o, resp_ready_i;
  logic [40:0] req0_i, req1_i, dmi_req_o;
  logic [33:0] resp_o, dmi_resp_i;
  logic        dmi_req_valid_o, dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_ready_o;
  logic        owner_o, timeout_o;

  dmi_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req0_i(req0_i), .req1_i(req1_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_o(resp_o),
    .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i), .dmi_req_o(dmi_req_o),
    .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o), .dmi_resp_i(dmi_resp_i),
    .owner_o(owner_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] onehot(input logic g);
    return g ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [40:0] rnd41();
    return 41'({$urandom(), $urandom()});
  endfunction

  // dm_top model reply: data XOR address, op echoed as response code.
  function automatic logic [33:0] dm_reply(input logic [40:0] r);
    return {r[33:2] ^ {25'h0, r[40:34]}, r[1:0]};
  endfunction

  task automatic idle_inputs();
    req_valid_i      = 2'b00;
    req0_i           = '0;
    req1_i           = '0;
    resp_ready_i     = 2'b00;
    dmi_req_ready_i  = 1'b0;
    dmi_resp_valid_i = 1'b0;
    dmi_resp_i       = '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"},  64'(req_ready_o),      64'(0));
    check({tag, "_resp_valid"}, 64'(resp_valid_o),     64'(0));
    check({tag, "_dmi_valid"},  64'(dmi_req_valid_o),  64'(0));
    check({tag, "_dmi_rready"}, 64'(dmi_resp_ready_o), 64'(0));
    check({tag, "_dmi_req"},    64'(dmi_req_o),        64'(0));
    check({tag, "_resp"},       64'(resp_o),           64'(0));
    check({tag, "_owner"},      64'(owner_o),          64'(1));
    check({tag, "_timeout"},    64'(timeout_o),        64'(0));
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    step();
    check_reset("reset");
    reset_n = 1'b1;
  endtask

  // Current pending payload per requester; changes only after that side is granted.
  logic [40:0] pay [2];

  // One complete transaction with a prompt dm_top, from IDLE back to IDLE.
  task automatic run_txn(input logic [1:0] v, input logic g, input logic [33:0] reply);
    logic [40:0] exp_req;
    req_valid_i = v;
    req0_i      = pay[0];
    req1_i      = pay[1];
    #1;
    check("grant_ready", 64'(req_ready_o), 64'(onehot(g)));
    exp_req = pay[g];
    step();
    pay[g]          = rnd41();
    req_valid_i     = v & ~onehot(g);
    req0_i          = pay[0];
    req1_i          = pay[1];
    dmi_req_ready_i = 1'b1;
    #1;
    check("issue_valid",   64'(dmi_req_valid_o), 64'(1));
    check("issue_payload", 64'(dmi_req_o),       64'(exp_req));
    check("issue_owner",   64'(owner_o),         64'(g));
    check("issue_no_rdy",  64'(req_ready_o),     64'(0));
    step();
    dmi_req_ready_i  = 1'b0;
    dmi_resp_valid_i = 1'b1;
    dmi_resp_i       = reply;
    #1;
    check("wait_no_resp", 64'(resp_valid_o), 64'(0));
    step();
    dmi_resp_valid_i = 1'b0;
    resp_ready_i     = onehot(g);
    #1;
    check("resp_valid",   64'(resp_valid_o), 64'(onehot(g)));
    check("resp_payload", 64'(resp_o),       64'(reply));
    step();
    resp_ready_i = 2'b00;
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic        grant;
    logic [33:0] reply;
  } vec_t;

  vec_t tbl [13];

  // Random-phase model state.
  logic [40:0] q0 [$];
  logic [40:0] q1 [$];
  logic [40:0] issued, exp_req_d;
  logic [33:0] exp_resp, hold_resp;
  logic [1:0]  vld, exp_rr, exp_rv;
  logic        busy, dm_acc, silent, own, last, pg;
  int          cyc, c0, dd, resp_at, done;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Starting from owner=1 after reset: grant pattern and dm_top reply per transaction.
    tbl[0]  = '{valid: 2'b11, grant: 1'b0, reply: 34'h0_A5A5_0001};
    tbl[1]  = '{valid: 2'b11, grant: 1'b1, reply: 34'h1_A5A5_0002};
    tbl[2]  = '{valid: 2'b11, grant: 1'b0, reply: 34'h2_A5A5_0003};
    tbl[3]  = '{valid: 2'b11, grant: 1'b1, reply: 34'h3_A5A5_0004};
    tbl[4]  = '{valid: 2'b11, grant: 1'b0, reply: 34'h0_5A5A_0005};
    tbl[5]  = '{valid: 2'b11, grant: 1'b1, reply: 34'h1_5A5A_0006};
    tbl[6]  = '{valid: 2'b01, grant: 1'b0, reply: 34'h2_5A5A_0007};
    tbl[7]  = '{valid: 2'b01, grant: 1'b0, reply: 34'h3_5A5A_0008};
    tbl[8]  = '{valid: 2'b11, grant: 1'b1, reply: 34'h0_0F0F_0009};
    tbl[9]  = '{valid: 2'b01, grant: 1'b0, reply: 34'h1_0F0F_000A};
    tbl[10] = '{valid: 2'b10, grant: 1'b1, reply: 34'h2_0F0F_000B};
    tbl[11] = '{valid: 2'b11, grant: 1'b0, reply: 34'h3_0F0F_000C};
    tbl[12] = '{valid: 2'b10, grant: 1'b1, reply: 34'h0_F0F0_000D};

    idle_inputs();
    reset_n = 1'b0;
    step();
    do_reset();

    // Single request from req0 with the reference payload.
    req_valid_i = 2'b01;
    req0_i      = {7'h10, 32'h1, 2'b10};
    #1;
    check("t1_ready", 64'(req_ready_o), 64'(2'b01));
    check("t1_no_same_cycle_issue", 64'(dmi_req_valid_o), 64'(0));
    step();
    req_valid_i = 2'b00;
    #1;
    check("t1_issue_valid", 64'(dmi_req_valid_o), 64'(1));
    check("t1_issue_req",   64'(dmi_req_o),       64'({7'h10, 32'h1, 2'b10}));
    dmi_req_ready_i = 1'b1;
    step();
    dmi_req_ready_i  = 1'b0;
    dmi_resp_valid_i = 1'b1;
    dmi_resp_i       = {32'h1, 2'b00};
    step();
    dmi_resp_valid_i = 1'b0;
    #1;
    check("t1_resp_valid", 64'(resp_valid_o), 64'(2'b01));
    check("t1_resp",       64'(resp_o),       64'(34'h4));
    resp_ready_i = 2'b01;
    step();
    resp_ready_i = 2'b00;
    #1;
    check("t1_resp_done", 64'(resp_valid_o), 64'(0));

    // Table of grant patterns from a fresh reset.
    do_reset();
    pay[0] = 41'h0AA_1111_1111;
    pay[1] = 41'h155_2222_2222;
    for (int i = 0; i < 13; i++) run_txn(tbl[i].valid, tbl[i].grant, tbl[i].reply);

    // dm_top stalls the request for 5 cycles while req1 is pending.
    req_valid_i = 2'b01;
    req0_i      = pay[0];
    #1;
    check("t3_grant0", 64'(req_ready_o), 64'(2'b01));
    exp_req_d = pay[0];
    step();
    req_valid_i = 2'b10;
    req1_i      = pay[1];
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_stall_valid", 64'(dmi_req_valid_o), 64'(1));
      check("t3_stall_req",   64'(dmi_req_o),       64'(exp_req_d));
      check("t3_no_grant",    64'(req_ready_o),     64'(0));
      step();
    end
    dmi_req_ready_i = 1'b1;
    step();
    dmi_req_ready_i  = 1'b0;
    dmi_resp_valid_i = 1'b1;
    dmi_resp_i       = 34'h2_DEAD_BEEF;
    step();
    dmi_resp_valid_i = 1'b0;
    dmi_resp_i       = '0;
    // Requester 0 stalls the response for 4 cycles.
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t5_hold_valid", 64'(resp_valid_o), 64'(2'b01));
      check("t5_hold_resp",  64'(resp_o),       64'(34'h2_DEAD_BEEF));
      check("t5_no_grant",   64'(req_ready_o),  64'(0));
      step();
    end
    resp_ready_i = 2'b01;
    step();
    resp_ready_i = 2'b00;
    #1;
    check("t5_then_grant1", 64'(req_ready_o), 64'(2'b10));
    step();
    req_valid_i = 2'b00;

    // dm_top never answers req1: error response after the timeout.
    dmi_req_ready_i = 1'b1;
    #1;
    check("t4_issue", 64'(dmi_req_valid_o), 64'(1));
    step();
    dmi_req_ready_i = 1'b0;
    for (int k = 0; k < int'(T); k++) begin
      #1;
      check("t4_early_timeout", 64'(timeout_o),    64'(0));
      check("t4_early_resp",    64'(resp_valid_o), 64'(0));
      step();
    end
    #1;
    check("t4_timeout_pulse", 64'(timeout_o),    64'(1));
    check("t4_err_valid",     64'(resp_valid_o), 64'(2'b10));
    check("t4_err_resp",      64'(resp_o),       64'(ERR_RESP));
    check("t4_owner",         64'(owner_o),      64'(1));
    step();
    #1;
    check("t4_pulse_end", 64'(timeout_o),    64'(0));
    check("t4_err_hold",  64'(resp_valid_o), 64'(2'b10));
    resp_ready_i = 2'b10;
    step();
    resp_ready_i     = 2'b00;
    dmi_resp_valid_i = 1'b1;
    dmi_resp_i       = 34'h1_2345_6789;
    #1;
    check("t4_stray_ready", 64'(dmi_resp_ready_o), 64'(1));
    step();
    dmi_resp_valid_i = 1'b0;
    #1;
    check("t4_stray_no_valid", 64'(resp_valid_o), 64'(0));
    check("t4_stray_dropped",  64'(resp_o),       64'(ERR_RESP));
    step();
    check("t4_stray_no_valid2", 64'(resp_valid_o), 64'(0));

    // Reset while waiting for dm_top, then normal operation.
    req_valid_i = 2'b01;
    req0_i      = pay[0];
    step();
    req_valid_i     = 2'b00;
    dmi_req_ready_i = 1'b1;
    step();
    dmi_req_ready_i = 1'b0;
    #1;
    check("t6_in_wait", 64'(dmi_resp_ready_o), 64'(1));
    reset_n = 1'b0;
    step();
    check_reset("t6_abort");
    reset_n = 1'b1;
    run_txn(2'b10, 1'b1, 34'h1_CAFE_0001);
    run_txn(2'b11, 1'b0, 34'h2_CAFE_0002);
    run_txn(2'b11, 1'b1, 34'h3_CAFE_0003);
    run_txn(2'b01, 1'b0, 34'h0_CAFE_0004);

    // Randomized traffic against the transaction-level model.
    do_reset();
    busy = 1'b0;
    dm_acc = 1'b0;
    silent = 1'b0;
    own = 1'b1;
    last = 1'b1;
    issued = '0;
    exp_resp = '0;
    hold_resp = '0;
    c0 = 0;
    dd = 0;
    resp_at = 0;
    cyc = 0;
    done = 0;
    while (done < 80 && cyc < 6000) begin
      vld              = {q1.size() != 0, q0.size() != 0};
      req_valid_i      = vld;
      req0_i           = vld[0] ? q0[0] : rnd41();
      req1_i           = vld[1] ? q1[0] : rnd41();
      resp_ready_i     = 2'($urandom_range(0, 3));
      dmi_req_ready_i  = ($urandom_range(0, 2) != 0);
      dmi_resp_valid_i = 1'b0;
      dmi_resp_i       = 34'(rnd41());
      if (busy && dm_acc && !silent && cyc == c0 + 1 + dd) begin
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i       = exp_resp;
      end else if (!busy && $urandom_range(0, 7) == 0) begin
        dmi_resp_valid_i = 1'b1;
      end
      #1;
      pg     = (&vld) ? ~last : vld[1];
      exp_rr = (!busy && vld != 2'b00) ? onehot(pg) : 2'b00;
      check("rnd_req_ready", 64'(req_ready_o), 64'(exp_rr));
      check("rnd_dmi_req_valid", 64'(dmi_req_valid_o), 64'(busy && !dm_acc));
      if (busy && !dm_acc) check("rnd_dmi_req", 64'(dmi_req_o), 64'(issued));
      exp_rv = (busy && dm_acc && cyc >= resp_at) ? onehot(own) : 2'b00;
      check("rnd_resp_valid", 64'(resp_valid_o), 64'(exp_rv));
      if (exp_rv != 2'b00) check("rnd_resp_data", 64'(resp_o), 64'(exp_resp));
      check("rnd_timeout", 64'(timeout_o), 64'(busy && dm_acc && silent && cyc == resp_at));

      if (!busy) begin
        if (vld != 2'b00) begin
          busy   = 1'b1;
          dm_acc = 1'b0;
          own    = pg;
          last   = pg;
          if (pg) issued = q1.pop_front();
          else    issued = q0.pop_front();
        end
      end else if (!dm_acc) begin
        if (dmi_req_ready_i) begin
          dm_acc   = 1'b1;
          c0       = cyc;
          dd       = int'($urandom_range(0, T + 1));
          silent   = (dd >= int'(T));
          resp_at  = silent ? cyc + int'(T) + 1 : cyc + 2 + dd;
          exp_resp = silent ? ERR_RESP : dm_reply(issued);
        end
      end else if (cyc >= resp_at && resp_ready_i[own]) begin
        busy = 1'b0;
        done++;
      end
      if (q0.size() < 3 && $urandom_range(0, 3) == 0) q0.push_back(rnd41());
      if (q1.size() < 3 && $urandom_range(0, 3) == 0) q1.push_back(rnd41());
      cyc++;
      step();
    end
    check("rnd_progress", 64'(done >= 80), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
